// File: rtl/pc_sequencer.sv
// pc_sequencer: registered fetch PC with jump/branch/indirect targets,
// exception and ERET redirect, and a circular return-address stack.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   stall_i                      hold PC, RAS and pulses this cycle
//   npc_op_i                     0 SEQ 1 JUMP 2 OFFSET 3 JAL 4 JR 5 RET
//   base_pc_i, imm16_i, imm26_i  operands of the control-flow op
//   rs_val_i                     register target for JR/RET
//   exc_i, eret_i, epc_i         exception entry / return redirect
//   pc_o                         registered fetch PC
//   link_o                       base_pc_i + 4 (combinational)
//   ras_top_o, ras_count_o       RAS top entry (0 if empty), depth used
//   ras_hit_o, ras_miss_o        one-cycle RET prediction outcome
//   adel_o                       one-cycle misaligned-PC flag
module pc_sequencer #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4,
    localparam int         CNT_W     = $clog2(RAS_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic [2:0]        npc_op_i,
    input  logic [ADDR_W-1:0] base_pc_i,
    input  logic [15:0]       imm16_i,
    input  logic [25:0]       imm26_i,
    input  logic [ADDR_W-1:0] rs_val_i,
    input  logic              exc_i,
    input  logic              eret_i,
    input  logic [ADDR_W-1:0] epc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] link_o,
    output logic [ADDR_W-1:0] ras_top_o,
    output logic [CNT_W-1:0]  ras_count_o,
    output logic              ras_hit_o,
    output logic              ras_miss_o,
    output logic              adel_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    localparam logic [2:0] OP_SEQ    = 3'd0;
    localparam logic [2:0] OP_JUMP   = 3'd1;
    localparam logic [2:0] OP_OFFSET = 3'd2;
    localparam logic [2:0] OP_JAL    = 3'd3;
    localparam logic [2:0] OP_JR     = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] b4;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] off_tgt;
    logic [ADDR_W-1:0] tgt_d;

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  top_q;
    logic [PTR_W-1:0]  push_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] ras_top;

    logic hit_q;
    logic miss_q;
    logic adel_q;

    assign seq     = pc_q + ADDR_W'(4);
    assign b4      = base_pc_i + ADDR_W'(4);
    assign jmp_tgt = {b4[ADDR_W-1:28], imm26_i, 2'b00};
    assign off_tgt = b4 + {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};

    always_comb begin
        tgt_d = seq;
        unique case (npc_op_i)
            OP_SEQ:    tgt_d = seq;
            OP_JUMP:   tgt_d = jmp_tgt;
            OP_OFFSET: tgt_d = off_tgt;
            OP_JAL:    tgt_d = jmp_tgt;
            OP_JR:     tgt_d = rs_val_i;
            OP_RET:    tgt_d = rs_val_i;
            default:   tgt_d = seq;
        endcase
    end

    // top_q points at the newest entry; a push pre-increments, so a
    // push into a full stack lands on the oldest slot and overwrites it.
    assign push_ptr  = top_q + PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    assign ras_top   = ras_empty ? '0 : ras_q[top_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RST_PC;
            top_q  <= '0;
            cnt_q  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            adel_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (exc_i) begin
            pc_q   <= EXC_PC;
            top_q  <= '0;
            cnt_q  <= '0;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            adel_q <= |EXC_PC[1:0];
        end else if (eret_i) begin
            pc_q   <= epc_i;
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            adel_q <= |epc_i[1:0];
        end else if (stall_i) begin
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            adel_q <= 1'b0;
        end else begin
            pc_q   <= tgt_d;
            adel_q <= |tgt_d[1:0];
            hit_q  <= 1'b0;
            miss_q <= 1'b0;
            if (npc_op_i == OP_JAL) begin
                ras_q[push_ptr] <= b4;
                top_q           <= push_ptr;
                if (!ras_full) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (npc_op_i == OP_RET) begin
                // Prediction check only; the PC always follows rs_val_i.
                if (ras_empty) begin
                    miss_q <= 1'b1;
                end else begin
                    hit_q  <= (ras_q[top_q] == rs_val_i);
                    miss_q <= (ras_q[top_q] != rs_val_i);
                    top_q  <= top_q - PTR_W'(1);
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign pc_o        = pc_q;
    assign link_o      = b4;
    assign ras_top_o   = ras_top;
    assign ras_count_o = cnt_q;
    assign ras_hit_o   = hit_q;
    assign ras_miss_o  = miss_q;
    assign adel_o      = adel_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vector table, multi-cycle reset corners,
// a 29-bit instance check and randomized run against a queue-based model.
module tb_pc_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        stall_i, exc_i, eret_i;
    logic [2:0]  op;
    logic [31:0] base, rs, epc;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] pc, link, top;
    logic [2:0]  cnt;
    logic        hit, miss, adel;

    logic [2:0]  op29 = 3'd0;
    logic [28:0] base29 = '0;
    logic [28:0] zero29 = '0;
    logic [25:0] imm26_29 = '0;
    logic [15:0] imm16_29 = '0;
    logic        low29 = 1'b0;
    logic [28:0] pc29, link29, top29;
    logic [2:0]  cnt29;
    logic        hit29, miss29, adel29;

    pc_sequencer dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .npc_op_i(op),
        .base_pc_i(base), .imm16_i(imm16), .imm26_i(imm26),
        .rs_val_i(rs), .exc_i(exc_i), .eret_i(eret_i), .epc_i(epc),
        .pc_o(pc), .link_o(link), .ras_top_o(top), .ras_count_o(cnt),
        .ras_hit_o(hit), .ras_miss_o(miss), .adel_o(adel)
    );

    pc_sequencer #(.ADDR_W(29)) dut29 (
        .clk(clk), .rst_n(rst_n), .stall_i(low29), .npc_op_i(op29),
        .base_pc_i(base29), .imm16_i(imm16_29), .imm26_i(imm26_29),
        .rs_val_i(zero29), .exc_i(low29), .eret_i(low29),
        .epc_i(zero29), .pc_o(pc29), .link_o(link29),
        .ras_top_o(top29), .ras_count_o(cnt29), .ras_hit_o(hit29),
        .ras_miss_o(miss29), .adel_o(adel29)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc,
                           input logic [31:0] e_top, input int e_cnt,
                           input logic e_hit, input logic e_miss,
                           input logic e_adel);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " top"}, top, e_top);
        chk({tag, " cnt"}, 32'(cnt), 32'(e_cnt));
        chk({tag, " hit"}, 32'(hit), 32'(e_hit));
        chk({tag, " miss"}, 32'(miss), 32'(e_miss));
        chk({tag, " adel"}, 32'(adel), 32'(e_adel));
    endtask

    typedef struct {
        logic        st, ex, er;
        logic [2:0]  op;
        logic [31:0] base;
        logic [15:0] i16;
        logic [25:0] i26;
        logic [31:0] rs, epc;
        logic [31:0] e_pc, e_top;
        int          e_cnt;
        logic        e_hit, e_miss, e_adel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic st, input logic ex, input logic er,
        input logic [2:0] o, input logic [31:0] b,
        input logic [15:0] i16, input logic [25:0] i26,
        input logic [31:0] r, input logic [31:0] ep,
        input logic [31:0] e_pc, input logic [31:0] e_top,
        input int e_cnt, input logic e_hit, input logic e_miss,
        input logic e_adel);
        vec_t v;
        v.st = st; v.ex = ex; v.er = er; v.op = o; v.base = b;
        v.i16 = i16; v.i26 = i26; v.rs = r; v.epc = ep;
        v.e_pc = e_pc; v.e_top = e_top; v.e_cnt = e_cnt;
        v.e_hit = e_hit; v.e_miss = e_miss; v.e_adel = e_adel;
        return v;
    endfunction

    task automatic drive(input logic st, input logic ex, input logic er,
                         input logic [2:0] o, input logic [31:0] b,
                         input logic [15:0] i16, input logic [25:0] i26,
                         input logic [31:0] r, input logic [31:0] ep);
        stall_i = st; exc_i = ex; eret_i = er; op = o; base = b;
        imm16 = i16; imm26 = i26; rs = r; epc = ep;
    endtask

    // Reference model: plain arithmetic and a queue (newest at back).
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_hit, m_miss, m_adel;

    task automatic model_reset();
        m_pc = 32'h3000;
        m_ras.delete();
        m_hit = 0; m_miss = 0; m_adel = 0;
    endtask

    task automatic model_step();
        logic [31:0] b4, t;
        b4 = base + 32'd4;
        m_hit = 0; m_miss = 0; m_adel = 0;
        if (exc_i) begin
            m_pc = 32'h4180;
            m_ras.delete();
            m_adel = (m_pc % 4) != 0;
        end else if (eret_i) begin
            m_pc = epc;
            m_adel = (m_pc % 4) != 0;
        end else if (!stall_i) begin
            case (op)
                3'd1, 3'd3: t = (b4 & 32'hF000_0000) | (32'(imm26) * 4);
                3'd2: t = b4 + 32'(int'($signed(imm16)) * 4);
                3'd4, 3'd5: t = rs;
                default: t = m_pc + 32'd4;
            endcase
            if (op == 3'd3) begin
                m_ras.push_back(b4);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end else if (op == 3'd5) begin
                if (m_ras.size() == 0) m_miss = 1;
                else begin
                    if (m_ras[$] == rs) m_hit = 1;
                    else m_miss = 1;
                    void'(m_ras.pop_back());
                end
            end
            m_pc = t;
            m_adel = (m_pc % 4) != 0;
        end
    endtask

    function automatic logic [31:0] m_top();
        return (m_ras.size() == 0) ? 32'h0 : m_ras[$];
    endfunction

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        drive(0, 0, 0, 3'd0, 32'h3000, 16'h0, 26'h0, 32'h0, 32'h0);

        // SEQ, OFFSET, JUMP
        tbl.push_back(mk(0,0,0,3'd0,32'h3000,16'h0,26'h0,0,0, 32'h3004,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd0,32'h3000,16'h0,26'h0,0,0, 32'h3008,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd0,32'h3000,16'h0,26'h0,0,0, 32'h300C,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd2,32'h3010,16'hFFFE,26'h0,0,0, 32'h300C,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd1,32'h3000,16'h0,26'h0C10,0,0, 32'h3040,0,0,0,0,0));
        // RAS round trip
        tbl.push_back(mk(0,0,0,3'd3,32'h3000,16'h0,26'h0C10,0,0, 32'h3040,32'h3004,1,0,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h3004,0, 32'h3004,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h3004,0, 32'h3004,0,0,0,1,0));
        // RAS overflow
        tbl.push_back(mk(0,0,0,3'd3,32'h100,16'h0,26'h040,0,0, 32'h100,32'h104,1,0,0,0));
        tbl.push_back(mk(0,0,0,3'd3,32'h200,16'h0,26'h080,0,0, 32'h200,32'h204,2,0,0,0));
        tbl.push_back(mk(0,0,0,3'd3,32'h300,16'h0,26'h0C0,0,0, 32'h300,32'h304,3,0,0,0));
        tbl.push_back(mk(0,0,0,3'd3,32'h400,16'h0,26'h100,0,0, 32'h400,32'h404,4,0,0,0));
        tbl.push_back(mk(0,0,0,3'd3,32'h500,16'h0,26'h140,0,0, 32'h500,32'h504,4,0,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h504,0, 32'h504,32'h404,3,1,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h404,0, 32'h404,32'h304,2,1,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h304,0, 32'h304,32'h204,1,1,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h204,0, 32'h204,0,0,1,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h204,0, 32'h204,0,0,0,1,0));
        // priority and misalignment
        tbl.push_back(mk(0,0,0,3'd3,32'h3000,16'h0,26'h0C10,0,0, 32'h3040,32'h3004,1,0,0,0));
        tbl.push_back(mk(1,0,0,3'd1,32'h0,16'h0,26'h100,0,0, 32'h3040,32'h3004,1,0,0,0));
        tbl.push_back(mk(1,1,1,3'd1,32'h0,16'h0,26'h100,0,32'h5000, 32'h4180,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd4,32'h0,16'h0,26'h0,32'h3002,0, 32'h3002,0,0,0,0,1));
        tbl.push_back(mk(0,0,0,3'd1,32'h3000,16'h0,26'h0C10,0,0, 32'h3040,0,0,0,0,0));
        tbl.push_back(mk(0,0,1,3'd1,32'h3000,16'h0,26'h0C10,0,32'h2000, 32'h2000,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd3,32'h3000,16'h0,26'h0C10,0,0, 32'h3040,32'h3004,1,0,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h3008,0, 32'h3008,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,3'd6,32'h0,16'h0,26'h0,0,0, 32'h300C,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,3'd5,32'h0,16'h0,26'h0,32'h300C,0, 32'h300C,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,3'd5,32'h0,16'h0,26'h0,32'h300C,0, 32'h300C,0,0,0,1,0));

        #12;
        chk_all("reset", 32'h3000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        chk_all("released", 32'h3000, 0, 0, 0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].st, tbl[i].ex, tbl[i].er, tbl[i].op, tbl[i].base,
                  tbl[i].i16, tbl[i].i26, tbl[i].rs, tbl[i].epc);
            #1;
            chk($sformatf("vec%0d link", i), link, tbl[i].base + 32'd4);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_top,
                    tbl[i].e_cnt, tbl[i].e_hit, tbl[i].e_miss,
                    tbl[i].e_adel);
        end

        // Fill past depth, stall, then async reset mid-stall.
        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 0, 3'd3, 32'(k * 256), 16'h0, 26'(k * 64), 0, 0);
            @(posedge clk);
            #1;
        end
        chk_all("ovf", 32'h500, 32'h504, 4, 0, 0, 0);
        drive(1, 0, 0, 3'd1, 32'h0, 16'h0, 26'h100, 0, 0);
        @(posedge clk);
        #1;
        chk_all("ovf stall", 32'h500, 32'h504, 4, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async rst", 32'h3000, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // 29-bit instance: b4 wraps to 0, region bit follows b4[28].
        op29 = 3'd1;
        base29 = 29'h1FFF_FFFC;
        imm26_29 = 26'h0C10;
        #1;
        chk("w29 link", 32'(link29), 32'h0);
        @(posedge clk);
        #1;
        chk("w29 pc", 32'(pc29), 32'h3040);
        base29 = 29'h1000_0000;
        #1;
        chk("w29 link2", 32'(link29), 32'h1000_0004);
        @(posedge clk);
        #1;
        chk("w29 pc2", 32'(pc29), 32'h1000_3040);
        op29 = 3'd0;

        // Randomized run against the model.
        drive(0, 0, 0, 3'd0, 32'h0, 16'h0, 26'h0, 0, 0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            stall_i = ($urandom_range(0, 3) == 0);
            exc_i = ($urandom_range(0, 31) == 0);
            eret_i = ($urandom_range(0, 15) == 0);
            op = 3'($urandom_range(0, 7));
            base = rnd_addr();
            imm16 = 16'($urandom);
            imm26 = 26'($urandom);
            epc = rnd_addr();
            if ($urandom_range(0, 1) == 1 && m_ras.size() > 0) rs = m_ras[$];
            else rs = rnd_addr();
            model_step();
            @(posedge clk);
            #1;
            chk_all($sformatf("rnd%0d", n), m_pc, m_top(),
                    m_ras.size(), m_hit, m_miss, m_adel);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
